// File: rtl/rx78_kbd_pkg.sv
// Shared definitions for the RX-78 key matrix: key sources, the scancode map,
// each source's matrix bits, joystick patterns and the Fn/modifier scancodes.
package rx78_kbd_pkg;

  typedef enum logic [4:0] {
    S_K0, S_K1, S_K2, S_K3, S_K4, S_K5, S_K6, S_K7, S_K8, S_K9,
    S_A, S_B, S_C, S_SPACE, S_RETURN, S_STOP,
    S_LSHIFT, S_RSHIFT, S_CTRL, S_F1
  } src_e;

  localparam int NUM_SRC = 20;

  typedef struct packed {
    logic valid;
    src_e src;
  } src_hit_t;

  // A source drives up to two matrix positions; mask1 == 0 means "unused".
  typedef struct packed {
    logic [3:0] row0;
    logic [7:0] mask0;
    logic [3:0] row1;
    logic [7:0] mask1;
  } src_map_t;

  typedef struct packed {
    logic [1:0] off;
    logic [7:0] mask;
  } joy_pat_t;

  localparam int JB_R  = 0;
  localparam int JB_L  = 1;
  localparam int JB_D  = 2;
  localparam int JB_U  = 3;
  localparam int JB_B1 = 4;
  localparam int JB_B2 = 5;

  localparam joy_pat_t JP_NONE = '{off: 2'd0, mask: 8'h00};
  localparam joy_pat_t JP_U    = '{off: 2'd0, mask: 8'h11};
  localparam joy_pat_t JP_UL   = '{off: 2'd0, mask: 8'h22};
  localparam joy_pat_t JP_UR   = '{off: 2'd0, mask: 8'h44};
  localparam joy_pat_t JP_DL   = '{off: 2'd0, mask: 8'h88};
  localparam joy_pat_t JP_D    = '{off: 2'd1, mask: 8'h11};
  localparam joy_pat_t JP_DR   = '{off: 2'd1, mask: 8'h22};
  localparam joy_pat_t JP_B1   = '{off: 2'd1, mask: 8'h44};
  localparam joy_pat_t JP_L    = '{off: 2'd1, mask: 8'h88};
  localparam joy_pat_t JP_R    = '{off: 2'd2, mask: 8'h44};
  localparam joy_pat_t JP_B2   = '{off: 2'd2, mask: 8'h88};

  // Index i holds the scancode of F<i>.
  localparam logic [11:1][7:0] FN_CODES = {
    8'h78, 8'h09, 8'h01, 8'h0A, 8'h83, 8'h0B, 8'h03, 8'h0C, 8'h04, 8'h06, 8'h05
  };
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  function automatic src_hit_t sc_to_src(input logic [7:0] code);
    src_hit_t hit;
    hit = '{valid: 1'b0, src: S_K0};
    case (code)
      8'h45: hit = '{valid: 1'b1, src: S_K0};
      8'h16: hit = '{valid: 1'b1, src: S_K1};
      8'h1E: hit = '{valid: 1'b1, src: S_K2};
      8'h26: hit = '{valid: 1'b1, src: S_K3};
      8'h25: hit = '{valid: 1'b1, src: S_K4};
      8'h2E: hit = '{valid: 1'b1, src: S_K5};
      8'h36: hit = '{valid: 1'b1, src: S_K6};
      8'h3D: hit = '{valid: 1'b1, src: S_K7};
      8'h3E: hit = '{valid: 1'b1, src: S_K8};
      8'h46: hit = '{valid: 1'b1, src: S_K9};
      8'h1C: hit = '{valid: 1'b1, src: S_A};
      8'h32: hit = '{valid: 1'b1, src: S_B};
      8'h21: hit = '{valid: 1'b1, src: S_C};
      8'h29: hit = '{valid: 1'b1, src: S_SPACE};
      8'h5A: hit = '{valid: 1'b1, src: S_RETURN};
      8'h76: hit = '{valid: 1'b1, src: S_STOP};
      8'h12: hit = '{valid: 1'b1, src: S_LSHIFT};
      8'h59: hit = '{valid: 1'b1, src: S_RSHIFT};
      8'h14: hit = '{valid: 1'b1, src: S_CTRL};
      8'h05: hit = '{valid: 1'b1, src: S_F1};
      default: hit = '{valid: 1'b0, src: S_K0};
    endcase
    return hit;
  endfunction

  function automatic src_map_t src_map(input src_e s);
    src_map_t m;
    m = '{row0: 4'd0, mask0: 8'h00, row1: 4'd0, mask1: 8'h00};
    case (s)
      S_K0:     m.mask0 = 8'h01;
      S_K1:     m.mask0 = 8'h02;
      S_K2:     m.mask0 = 8'h04;
      S_K3:     m.mask0 = 8'h08;
      S_K4:     m.mask0 = 8'h10;
      S_K5:     m.mask0 = 8'h20;
      S_K6:     m.mask0 = 8'h40;
      S_K7:     m.mask0 = 8'h80;
      S_K8:     begin m.row0 = 4'd1; m.mask0 = 8'h01; end
      S_K9:     begin m.row0 = 4'd1; m.mask0 = 8'h02; end
      S_A:      begin m.row0 = 4'd2; m.mask0 = 8'h02; end
      S_B:      begin m.row0 = 4'd2; m.mask0 = 8'h04; end
      S_C:      begin m.row0 = 4'd2; m.mask0 = 8'h08; end
      S_SPACE:  begin m.row0 = 4'd6; m.mask0 = 8'h01; end
      S_RETURN: begin m.row0 = 4'd7; m.mask0 = 8'h01; end
      // STOP doubles as a shift so the ROM sees SHIFT+BREAK.
      S_STOP:   begin m.row0 = 4'd7; m.mask0 = 8'h08; m.row1 = 4'd8; m.mask1 = 8'h04; end
      S_LSHIFT: begin m.row0 = 4'd8; m.mask0 = 8'h04; end
      S_RSHIFT: begin m.row0 = 4'd8; m.mask0 = 8'h04; end
      S_CTRL:   begin m.row0 = 4'd8; m.mask0 = 8'h01; end
      S_F1:     begin m.row0 = 4'd7; m.mask0 = 8'h10; end
      default:  m.mask0 = 8'h00;
    endcase
    return m;
  endfunction

  // Diagonals win over cardinals so a held diagonal never splits into two codes.
  function automatic joy_pat_t joy_dir(input logic [5:0] b);
    joy_pat_t p;
    if (b[JB_U] && b[JB_L])      p = JP_UL;
    else if (b[JB_D] && b[JB_L]) p = JP_DL;
    else if (b[JB_U] && b[JB_R]) p = JP_UR;
    else if (b[JB_D] && b[JB_R]) p = JP_DR;
    else if (b[JB_U])            p = JP_U;
    else if (b[JB_D])            p = JP_D;
    else if (b[JB_L])            p = JP_L;
    else if (b[JB_R])            p = JP_R;
    else                         p = JP_NONE;
    return p;
  endfunction

endpackage

// File: rtl/rx78_keymatrix_hold_key_hold_cell.sv
// One key source: stays asserted for at least MIN_HOLD scan ticks after a press,
// deferring an early release until the hold counter runs out.
module key_hold_cell #(
  parameter int HOLD_W   = 4,
  parameter int MIN_HOLD = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic press,
  input  logic rel,
  output logic asserted
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD);

  logic              pending;
  logic [HOLD_W-1:0] cnt;
  logic              asserted_nx;
  logic              pending_nx;
  logic [HOLD_W-1:0] cnt_tick;
  logic [HOLD_W-1:0] cnt_nx;

  // Tick is applied before the event so a release on the expiring tick clears at once.
  always_comb begin
    if (tick && cnt != '0) cnt_tick = cnt - HOLD_W'(1);
    else                   cnt_tick = cnt;

    asserted_nx = asserted;
    pending_nx  = pending;
    cnt_nx      = cnt_tick;

    if (pending && cnt_tick == '0) begin
      asserted_nx = 1'b0;
      pending_nx  = 1'b0;
    end else begin
      pending_nx  = pending;
    end

    if (press) begin
      asserted_nx = 1'b1;
      pending_nx  = 1'b0;
      cnt_nx      = HOLD_LOAD;
    end else if (rel) begin
      if (cnt_tick == '0) begin
        asserted_nx = 1'b0;
        pending_nx  = 1'b0;
      end else begin
        pending_nx  = 1'b1;
      end
    end else begin
      cnt_nx = cnt_tick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asserted <= 1'b0;
      pending  <= 1'b0;
      cnt      <= '0;
    end else begin
      asserted <= asserted_nx;
      pending  <= pending_nx;
      cnt      <= cnt_nx;
    end
  end

endmodule

// File: rtl/rx78_keymatrix_hold.sv
// RX-78 keyboard/joystick matrix with guaranteed minimum key hold per source,
// plus direct F-key and modifier state.
module rx78_keymatrix_hold
  import rx78_kbd_pkg::*;
#(
  parameter int          KEY_ROWS = 9,
  parameter int          NUM_JOY  = 2,
  parameter int          JOY_ROWS = 3,
  parameter int          HOLD_W   = 4,
  parameter int          MIN_HOLD = 3,
  parameter logic [7:0]  ALL_ADDR = 8'h30
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [10:0]           ps2_key,
  input  logic [7:0]            addr,
  input  logic                  tick,
  input  logic [NUM_JOY*32-1:0] joy,
  output logic [7:0]            kb_rows,
  output logic [11:1]           Fn,
  output logic [2:0]            modif
);

  localparam int NUM_ROWS = KEY_ROWS + NUM_JOY * JOY_ROWS;
  localparam int JR       = NUM_JOY * JOY_ROWS;

  if (MIN_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_min_hold
    $error("MIN_HOLD does not fit in a HOLD_W-bit hold counter");
  end

  logic               tog_r;
  logic               evt;
  logic               evt_pressed;
  logic [7:0]         evt_code;
  src_hit_t           hit;
  logic [NUM_SRC-1:0] press_v;
  logic [NUM_SRC-1:0] rel_v;
  logic [NUM_SRC-1:0] asserted_v;
  logic [7:0]         joy_rows_r [JR];
  logic [7:0]         joy_nx     [JR];
  logic [7:0]         rows       [NUM_ROWS];
  logic [7:0]         all_or;
  logic               unused_ok;

  assign unused_ok   = ^{ps2_key[8], joy};
  assign evt         = ps2_key[10] ^ tog_r;
  assign evt_pressed = ps2_key[9];
  assign evt_code    = ps2_key[7:0];
  assign hit         = sc_to_src(evt_code);

  // The toggle reloads during reset too, so leaving reset never looks like an event.
  always_ff @(posedge clk_sys) begin
    tog_r <= ps2_key[10];
  end

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (evt && hit.valid && hit.src == src_e'(s)) begin
        press_v[s] = evt_pressed;
        rel_v[s]   = ~evt_pressed;
      end else begin
        press_v[s] = 1'b0;
        rel_v[s]   = 1'b0;
      end
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    key_hold_cell #(
      .HOLD_W   (HOLD_W),
      .MIN_HOLD (MIN_HOLD)
    ) u_cell (
      .clk      (clk_sys),
      .reset    (reset),
      .tick     (tick),
      .press    (press_v[s]),
      .rel      (rel_v[s]),
      .asserted (asserted_v[s])
    );
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      Fn    <= '0;
      modif <= '0;
    end else if (evt) begin
      for (int i = 1; i <= 11; i++) begin
        if (evt_code == FN_CODES[i]) Fn[i] <= evt_pressed;
      end
      if (evt_code == SC_RSHIFT) modif[0] <= evt_pressed;
      if (evt_code == SC_ALT)    modif[1] <= evt_pressed;
      if (evt_code == SC_CTRL)   modif[2] <= evt_pressed;
    end else begin
      Fn    <= Fn;
      modif <= modif;
    end
  end

  always_comb begin
    for (int j = 0; j < JR; j++) joy_nx[j] = 8'h00;
    for (int c = 0; c < NUM_JOY; c++) begin
      joy_pat_t p;
      logic [5:0] b;
      b = joy[c*32 +: 6];
      p = joy_dir(b);
      if (int'(p.off) < JOY_ROWS) joy_nx[c*JOY_ROWS + int'(p.off)] |= p.mask;
      if (b[JB_B1] && int'(JP_B1.off) < JOY_ROWS) joy_nx[c*JOY_ROWS + int'(JP_B1.off)] |= JP_B1.mask;
      if (b[JB_B2] && int'(JP_B2.off) < JOY_ROWS) joy_nx[c*JOY_ROWS + int'(JP_B2.off)] |= JP_B2.mask;
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int j = 0; j < JR; j++) begin
      if (reset) joy_rows_r[j] <= 8'h00;
      else       joy_rows_r[j] <= joy_nx[j];
    end
  end

  // Each matrix bit is the OR of every source mapped onto it.
  always_comb begin
    for (int r = 0; r < KEY_ROWS; r++) rows[r] = 8'h00;
    for (int j = 0; j < JR; j++) rows[KEY_ROWS + j] = joy_rows_r[j];
    for (int s = 0; s < NUM_SRC; s++) begin
      src_map_t m;
      m = src_map(src_e'(s));
      if (asserted_v[s]) begin
        if (int'(m.row0) < KEY_ROWS) rows[m.row0] |= m.mask0;
        if (int'(m.row1) < KEY_ROWS) rows[m.row1] |= m.mask1;
      end
    end
  end

  always_comb begin
    all_or  = 8'h00;
    kb_rows = 8'h00;
    for (int r = 0; r < NUM_ROWS; r++) all_or |= rows[r];
    if (addr == ALL_ADDR) begin
      kb_rows = all_or;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (int'(addr) == r + 1) kb_rows = rows[r];
      end
    end
  end

endmodule

// File: tb/tb_rx78_keymatrix_hold.sv
// Directed bench for rx78_keymatrix_hold: hold timing, shared matrix bits,
// release/tick coincidence, Fn/modif, joysticks, read decode and reset.
module tb_rx78_keymatrix_hold;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  addr;
  logic        tick;
  logic [63:0] joy;
  logic [7:0]  kb_rows;
  logic [11:1] Fn;
  logic [2:0]  modif;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  rx78_keymatrix_hold dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .addr    (addr),
    .tick    (tick),
    .joy     (joy),
    .kb_rows (kb_rows),
    .Fn      (Fn),
    .modif   (modif)
  );

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send_key(input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    cyc();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    n_tests++; if (Fn !== 11'h000) begin n_fail++; $display("FAIL reset_fn: got %h want %h", Fn, 11'h000); end
    n_tests++; if (modif !== 3'b000) begin n_fail++; $display("FAIL reset_modif: got %b want %b", modif, 3'b000); end
    rd(8'h30);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL reset_all: got %h want %h", kb_rows, 8'h00); end
    reset = 1'b0;
    idle(2);
    rd(8'h0A);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL reset_row9: got %h want %h", kb_rows, 8'h00); end
  endtask

  task automatic test_hold_tap();
    logic [7:0] exp;
    send_key(1'b1, 8'h1C);
    rd(8'h03);
    n_tests++; if (kb_rows !== 8'h02) begin n_fail++; $display("FAIL tap_press: got %h want %h", kb_rows, 8'h02); end
    send_key(1'b0, 8'h1C);
    rd(8'h03);
    n_tests++; if (kb_rows !== 8'h02) begin n_fail++; $display("FAIL tap_release_held: got %h want %h", kb_rows, 8'h02); end
    for (int k = 1; k <= 3; k++) begin
      idle(99);
      pulse_tick();
      rd(8'h03);
      exp = (k < 3) ? 8'h02 : 8'h00;
      n_tests++; if (kb_rows !== exp) begin n_fail++; $display("FAIL tap_tick%0d: got %h want %h", k, kb_rows, exp); end
    end
  endtask

  task automatic test_shift_stop();
    send_key(1'b1, 8'h12);
    send_key(1'b1, 8'h76);
    rd(8'h08);
    n_tests++; if (kb_rows !== 8'h08) begin n_fail++; $display("FAIL stop_row7: got %h want %h", kb_rows, 8'h08); end
    rd(8'h09);
    n_tests++; if (kb_rows !== 8'h04) begin n_fail++; $display("FAIL stop_row8: got %h want %h", kb_rows, 8'h04); end
    send_key(1'b0, 8'h76);
    for (int k = 0; k < 3; k++) begin idle(5); pulse_tick(); end
    rd(8'h08);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL stop_row7_clear: got %h want %h", kb_rows, 8'h00); end
    rd(8'h09);
    n_tests++; if (kb_rows !== 8'h04) begin n_fail++; $display("FAIL lshift_still_held: got %h want %h", kb_rows, 8'h04); end
    send_key(1'b0, 8'h12);
    rd(8'h09);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL lshift_release: got %h want %h", kb_rows, 8'h00); end
  endtask

  task automatic test_release_on_tick();
    send_key(1'b1, 8'h29);
    pulse_tick();
    pulse_tick();
    rd(8'h07);
    n_tests++; if (kb_rows !== 8'h01) begin n_fail++; $display("FAIL space_held: got %h want %h", kb_rows, 8'h01); end
    tick = 1'b1;
    send_key(1'b0, 8'h29);
    tick = 1'b0;
    rd(8'h07);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL space_rel_on_tick: got %h want %h", kb_rows, 8'h00); end
    send_key(1'b1, 8'h29);
    send_key(1'b0, 8'h29);
    pulse_tick();
    send_key(1'b1, 8'h29);
    send_key(1'b0, 8'h29);
    pulse_tick();
    pulse_tick();
    rd(8'h07);
    n_tests++; if (kb_rows !== 8'h01) begin n_fail++; $display("FAIL space_reload: got %h want %h", kb_rows, 8'h01); end
    pulse_tick();
    rd(8'h07);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL space_reload_expire: got %h want %h", kb_rows, 8'h00); end
  endtask

  task automatic test_fn_modif();
    send_key(1'b1, 8'h59);
    n_tests++; if (modif !== 3'b001) begin n_fail++; $display("FAIL rshift_modif: got %b want %b", modif, 3'b001); end
    send_key(1'b1, 8'h14);
    rd(8'h09);
    n_tests++; if (kb_rows !== 8'h05) begin n_fail++; $display("FAIL shift_ctrl_row8: got %h want %h", kb_rows, 8'h05); end
    send_key(1'b1, 8'h83);
    n_tests++; if (Fn !== 11'h040) begin n_fail++; $display("FAIL f7_press: got %h want %h", Fn, 11'h040); end
    send_key(1'b0, 8'h83);
    n_tests++; if (Fn !== 11'h000) begin n_fail++; $display("FAIL f7_release: got %h want %h", Fn, 11'h000); end
    send_key(1'b0, 8'h59);
    n_tests++; if (modif !== 3'b100) begin n_fail++; $display("FAIL rshift_release_modif: got %b want %b", modif, 3'b100); end
    rd(8'h09);
    n_tests++; if (kb_rows !== 8'h05) begin n_fail++; $display("FAIL rshift_row_held: got %h want %h", kb_rows, 8'h05); end
    send_key(1'b0, 8'h14);
    n_tests++; if (modif !== 3'b000) begin n_fail++; $display("FAIL ctrl_release_modif: got %b want %b", modif, 3'b000); end
    for (int k = 0; k < 3; k++) pulse_tick();
    rd(8'h09);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL mod_rows_clear: got %h want %h", kb_rows, 8'h00); end
  endtask

  task automatic test_joystick();
    joy = 64'h0;
    joy[3:0] = 4'b1010;
    rd(8'h0A);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL joy_latency: got %h want %h", kb_rows, 8'h00); end
    cyc();
    rd(8'h0A);
    n_tests++; if (kb_rows !== 8'h22) begin n_fail++; $display("FAIL joy0_ul: got %h want %h", kb_rows, 8'h22); end
    joy[32] = 1'b1;
    joy[37] = 1'b1;
    cyc();
    rd(8'h0F);
    n_tests++; if (kb_rows !== 8'hCC) begin n_fail++; $display("FAIL joy1_r_b2: got %h want %h", kb_rows, 8'hCC); end
    joy[3:0] = 4'b1111;
    cyc();
    rd(8'h0B);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL joy0_all_dirs_row10: got %h want %h", kb_rows, 8'h00); end
    joy[4:0] = 5'b10100;
    cyc();
    rd(8'h0B);
    n_tests++; if (kb_rows !== 8'h55) begin n_fail++; $display("FAIL joy0_d_b1: got %h want %h", kb_rows, 8'h55); end
    rd(8'h0A);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL joy0_row9_idle: got %h want %h", kb_rows, 8'h00); end
    joy = 64'h0;
    cyc();
  endtask

  task automatic test_all_or();
    send_key(1'b1, 8'h1C);
    send_key(1'b1, 8'h29);
    joy[3] = 1'b1;
    cyc();
    rd(8'h30);
    n_tests++; if (kb_rows !== 8'h13) begin n_fail++; $display("FAIL all_or: got %h want %h", kb_rows, 8'h13); end
    rd(8'h10);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL addr_out_of_range: got %h want %h", kb_rows, 8'h00); end
    rd(8'h00);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL addr_zero: got %h want %h", kb_rows, 8'h00); end
    joy = 64'h0;
    send_key(1'b0, 8'h1C);
    send_key(1'b0, 8'h29);
    for (int k = 0; k < 3; k++) pulse_tick();
    rd(8'h30);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL all_or_clear: got %h want %h", kb_rows, 8'h00); end
  endtask

  task automatic test_reset_mid_hold();
    if (ps2_key[10]) send_key(1'b1, 8'h7F);
    send_key(1'b1, 8'h1C);
    send_key(1'b0, 8'h1C);
    send_key(1'b1, 8'h03);
    n_tests++; if (Fn !== 11'h010) begin n_fail++; $display("FAIL f5_press: got %h want %h", Fn, 11'h010); end
    reset = 1'b1;
    cyc();
    rd(8'h30);
    n_tests++; if (kb_rows !== 8'h00 || Fn !== 11'h000 || modif !== 3'b000) begin
      n_fail++; $display("FAIL mid_hold_reset: got rows %h fn %h modif %b want 00 000 0", kb_rows, Fn, modif);
    end
    cyc();
    reset = 1'b0;
    idle(3);
    rd(8'h30);
    n_tests++; if (kb_rows !== 8'h00 || Fn !== 11'h000) begin
      n_fail++; $display("FAIL no_event_after_reset: got rows %h fn %h want 00 000", kb_rows, Fn);
    end
    reset = 1'b1;
    send_key(1'b1, 8'h1C);
    reset = 1'b0;
    idle(2);
    rd(8'h03);
    n_tests++; if (kb_rows !== 8'h00) begin n_fail++; $display("FAIL reset_beats_event: got %h want %h", kb_rows, 8'h00); end
  endtask

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h000;
    addr    = 8'h00;
    tick    = 1'b0;
    joy     = 64'h0;
    test_reset();
    test_hold_tap();
    test_shift_stop();
    test_release_on_tick();
    test_fn_modif();
    test_joystick();
    test_all_or();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
